// File: rtl/program_loader.sv
// Byte-stream program loader: parses a framed, XOR-checksummed image into
// 16-bit words and streams them to the CPU program-download port.
module program_loader #(
  parameter int         MAX_WORDS = 1024,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        download_program,
  output logic [31:0] instruction_index,
  output logic [15:0] program_in,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_CHECK
  } state_t;

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  xor_q, xor_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] prog_q, prog_d;
  logic        dl_q, dl_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        rdy_q, rdy_d;

  logic        accept;
  logic [15:0] n_word;
  logic [15:0] cnt_inc;

  assign accept  = rx_valid & rdy_q;
  assign n_word  = {rx_data, len_q[7:0]};
  assign cnt_inc = cnt_q + 16'd1;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    xor_d   = xor_q;
    lo_d    = lo_q;
    idx_d   = idx_q;
    prog_d  = prog_q;
    dl_d    = dl_q;
    done_d  = 1'b0;
    err_d   = err_q;
    rdy_d   = 1'b1;
    if (accept) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            err_d   = 1'b0;
            state_d = S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          len_d   = {8'h00, rx_data};
          xor_d   = rx_data;
          state_d = S_LEN_HI;
        end
        S_LEN_HI: begin
          len_d = n_word;
          xor_d = xor_q ^ rx_data;
          // A rejected length leaves download_program as it was.
          if (n_word == 16'd0 || {1'b0, n_word} > MAX_W) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            dl_d    = 1'b1;
            cnt_d   = 16'd0;
            state_d = S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          lo_d    = rx_data;
          xor_d   = xor_q ^ rx_data;
          state_d = S_DATA_HI;
        end
        S_DATA_HI: begin
          prog_d  = {rx_data, lo_q};
          idx_d   = cnt_q;
          cnt_d   = cnt_inc;
          xor_d   = xor_q ^ rx_data;
          state_d = (cnt_inc == len_q) ? S_CHECK : S_DATA_LO;
        end
        S_CHECK: begin
          // On mismatch the CPU stays halted until a good frame arrives.
          if (rx_data == xor_q) begin
            dl_d   = 1'b0;
            done_d = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      xor_q   <= '0;
      lo_q    <= '0;
      idx_q   <= '0;
      prog_q  <= '0;
      dl_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      xor_q   <= xor_d;
      lo_q    <= lo_d;
      idx_q   <= idx_d;
      prog_q  <= prog_d;
      dl_q    <= dl_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  assign rx_ready          = rdy_q;
  assign download_program  = dl_q;
  assign instruction_index = {16'h0000, idx_q};
  assign program_in        = prog_q;
  assign done              = done_q;
  assign error             = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomised frame-level bench for program_loader: a frame-oriented model
// predicts every output each cycle; literal checks pin the model.
module tb_program_loader;
  localparam int MAXW = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready, download_program, done, error;
  logic [31:0] instruction_index;
  logic [15:0] program_in;

  program_loader #(.MAX_WORDS(MAXW), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .download_program(download_program),
    .instruction_index(instruction_index), .program_in(program_in),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        m_rdy = 1'b0, m_dl = 1'b0, m_done = 1'b0, m_err = 1'b0;
  logic [31:0] m_idx = '0;
  logic [15:0] m_prog = '0;
  bit          chk_on = 1'b0;
  bit          stall = 1'b0;
  logic [15:0] wd [64];
  int          ndone = 0;

  typedef struct { logic [31:0] i; logic [15:0] w; } wr_t;
  wr_t         wlog [$];
  logic [47:0] last = '0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model; done is a one-cycle event.
  always @(negedge clk) begin
    if (chk_on) begin
      cmp("rx_ready", {31'd0, rx_ready}, {31'd0, m_rdy});
      cmp("download_program", {31'd0, download_program}, {31'd0, m_dl});
      cmp("instruction_index", instruction_index, m_idx);
      cmp("program_in", {16'd0, program_in}, {16'd0, m_prog});
      cmp("done", {31'd0, done}, {31'd0, m_done});
      cmp("error", {31'd0, error}, {31'd0, m_err});
      m_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      if (done === 1'b1) ndone++;
      if (download_program === 1'b1 && {instruction_index, program_in} !== last)
        wlog.push_back('{instruction_index, program_in});
      last = {instruction_index, program_in};
    end
  end

  task automatic put(input logic [7:0] b);
    if (stall) repeat ($urandom_range(0, 5)) @(negedge clk);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    m_rdy = 0; m_dl = 0; m_done = 0; m_err = 0; m_idx = '0; m_prog = '0;
    chk_on = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 m_rdy = 1'b1;
  endtask

  task automatic frame(input logic [15:0] n, input bit bad);
    logic [7:0] x;
    put(8'hA5);
    m_err = 1'b0;
    put(n[7:0]);
    put(n[15:8]);
    x = n[7:0] ^ n[15:8];
    if (n == 16'd0 || int'(n) > MAXW) begin
      m_err = 1'b1;
      return;
    end
    m_dl = 1'b1;
    for (int i = 0; i < int'(n); i++) begin
      put(wd[i][7:0]);
      put(wd[i][15:8]);
      x = x ^ wd[i][7:0] ^ wd[i][15:8];
      m_idx  = i;
      m_prog = wd[i];
    end
    put(bad ? ~x : x);
    if (bad) m_err = 1'b1;
    else begin
      m_dl   = 1'b0;
      m_done = 1'b1;
    end
  endtask

  task automatic idle(input int c);
    repeat (c) @(negedge clk);
  endtask

  initial begin
    logic [7:0] g;
    do_reset();

    // Basic two-word load.
    wd[0] = 16'h1234; wd[1] = 16'h5678;
    wlog.delete(); ndone = 0;
    frame(16'd2, 1'b0);
    idle(3);
    cmp("lit_nwrites", wlog.size(), 2);
    cmp("lit_w0", {wlog[0].i[15:0], wlog[0].w}, 32'h0000_1234);
    cmp("lit_w1", {wlog[1].i[15:0], wlog[1].w}, 32'h0001_5678);
    cmp("lit_ndone", ndone, 1);
    cmp("lit_err0", {31'd0, error}, 32'd0);

    // Bad checksum then recovery.
    frame(16'd2, 1'b1);
    idle(2);
    cmp("lit_badchk_err", {31'd0, error}, 32'd1);
    cmp("lit_badchk_dl", {31'd0, download_program}, 32'd1);
    frame(16'd2, 1'b0);
    idle(2);
    cmp("lit_recover_err", {31'd0, error}, 32'd0);

    // Garbage before sync.
    put(8'h00); put(8'hFF); put(8'h13);
    wd[0] = 16'hBEEF;
    wlog.delete(); ndone = 0;
    frame(16'd1, 1'b0);
    idle(2);
    cmp("lit_garbage_nwrites", wlog.size(), 1);
    cmp("lit_garbage_w0", {wlog[0].i[15:0], wlog[0].w}, 32'h0000_BEEF);
    cmp("lit_garbage_ndone", ndone, 1);

    // Length violations.
    wlog.delete();
    frame(16'd0, 1'b0);
    idle(1);
    frame(16'd1025, 1'b0);
    idle(2);
    cmp("lit_len_err", {31'd0, error}, 32'd1);
    cmp("lit_len_dl", {31'd0, download_program}, 32'd0);
    cmp("lit_len_nwrites", wlog.size(), 0);

    // Reset after three payload bytes of a four-word frame.
    for (int i = 0; i < 4; i++) wd[i] = 16'($urandom);
    put(8'hA5); m_err = 1'b0;
    put(8'h04); put(8'h00); m_dl = 1'b1;
    put(wd[0][7:0]); put(wd[0][15:8]); m_idx = 0; m_prog = wd[0];
    put(wd[1][7:0]);
    do_reset();
    for (int i = 0; i < 4; i++) wd[i] = 16'($urandom);
    wlog.delete();
    frame(16'd4, 1'b0);
    idle(2);
    cmp("lit_after_reset_idx0", wlog[0].i, 32'd0);
    cmp("lit_after_reset_nwrites", wlog.size(), 4);

    // Stalled repeat of the first frame.
    stall = 1'b1;
    wd[0] = 16'h1234; wd[1] = 16'h5678;
    wlog.delete(); ndone = 0;
    frame(16'd2, 1'b0);
    idle(3);
    cmp("lit_stall_w0", {wlog[0].i[15:0], wlog[0].w}, 32'h0000_1234);
    cmp("lit_stall_w1", {wlog[1].i[15:0], wlog[1].w}, 32'h0001_5678);
    cmp("lit_stall_ndone", ndone, 1);

    // Random frames, payload sync bytes and idle garbage.
    for (int t = 0; t < 30; t++) begin
      stall = $urandom_range(0, 1) == 1;
      for (int i = 0; i < 64; i++) wd[i] = 16'($urandom);
      if (t % 5 == 0) wd[0] = 16'hA5A5;
      repeat ($urandom_range(0, 2)) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h5A;
        put(g);
      end
      frame(16'($urandom_range(1, 40)), $urandom_range(0, 3) == 0);
      idle($urandom_range(0, 3));
    end
    stall = 1'b0;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
